// File: rtl/pipe_pkg.sv
// Shared widths and payload layout for the parametrised inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 25;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEST_W_DEF = 5;

  // Payload layout at default widths; the top packs ports in this same order.
  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] data;
    logic [DEST_W_DEF-1:0] dest;
  } payload_t;

  localparam payload_t PAYLOAD_ZERO = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a main register plus a one-entry skid buffer, so that the
// upstream ready is a registered bit with no combinational path from out_ready.
module pipe_skid_slot #(
  parameter int unsigned W           = 62,
  parameter bit          BUBBLE_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic         skid_valid
);

  logic         main_valid;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         advance;

  // Main may load a new entry when it is empty or its beat leaves this edge.
  always_comb begin
    advance = out_ready || !main_valid;
  end

  // Slot state update: reset beats flush, flush beats the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      if (BUBBLE_ZERO) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (advance) begin
      if (skid_valid) begin
        // Skid entry is older than anything upstream, so it drains first;
        // in_ready is low this cycle, so no input beat is taken.
        main_valid <= 1'b1;
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        if (BUBBLE_ZERO) begin
          skid_q <= '0;
        end
      end else begin
        main_valid <= in_valid;
        if (in_valid) begin
          main_q <= in_payload;
        end else if (BUBBLE_ZERO) begin
          main_q <= '0;
        end
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_q     <= in_payload;
    end
  end

  assign in_ready    = !skid_valid;
  assign out_valid   = main_valid;
  assign out_payload = main_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Parametrised inter-stage pipeline register: NUM_STAGES chained skid slots
// carrying control bundle, data word and destination index, with flush and
// bubble insertion handled locally instead of by clock gating.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = CTRL_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEST_W      = DEST_W_DEF,
  parameter int unsigned NUM_STAGES  = 1,
  parameter bit          BUBBLE_ZERO = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CTRL_W-1:0]                   control_signals,
  input  logic [DATA_W-1:0]                   data_in,
  input  logic [DEST_W-1:0]                   destination,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CTRL_W-1:0]                   control_signals_out,
  output logic [DATA_W-1:0]                   data_out,
  output logic [DEST_W-1:0]                   destination_out,
  output logic [$clog2(2*NUM_STAGES+1)-1:0]   occupancy
);

  localparam int unsigned PW    = CTRL_W + DATA_W + DEST_W;
  localparam int unsigned OCC_W = $clog2(2*NUM_STAGES+1);

  // Index k is the in side of slot k; index NUM_STAGES is the block output.
  logic [NUM_STAGES:0]   vld;
  logic [NUM_STAGES:0]   rdy;
  logic [PW-1:0]         pay [NUM_STAGES+1];
  logic [NUM_STAGES-1:0] skid_v;
  logic [OCC_W-1:0]      occ;

  assign vld[0]          = in_valid;
  assign pay[0]          = {control_signals, data_in, destination};
  assign in_ready        = rdy[0];
  assign rdy[NUM_STAGES] = out_ready;
  assign out_valid       = vld[NUM_STAGES];
  assign {control_signals_out, data_out, destination_out} = pay[NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
    pipe_skid_slot #(
      .W           (PW),
      .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (vld[k]),
      .in_ready    (rdy[k]),
      .in_payload  (pay[k]),
      .out_valid   (vld[k+1]),
      .out_ready   (rdy[k+1]),
      .out_payload (pay[k+1]),
      .skid_valid  (skid_v[k])
    );
  end

  // Occupancy counts every valid main and skid entry; all inputs are flops.
  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      occ = occ + OCC_W'(vld[i+1]) + OCC_W'(skid_v[i]);
    end
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg at NUM_STAGES=2, BUBBLE_ZERO=1.
module tb_pipe_stage_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] control_signals;
  logic [31:0] data_in;
  logic [4:0]  destination;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] control_signals_out;
  logic [31:0] data_out;
  logic [4:0]  destination_out;
  logic [2:0]  occupancy;

  int nvec = 0;
  int nerr = 0;
  logic [61:0] sb_q[$];

  pipe_stage_skid_reg #(
    .CTRL_W      (25),
    .DATA_W      (32),
    .DEST_W      (5),
    .NUM_STAGES  (2),
    .BUBBLE_ZERO (1'b1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .control_signals     (control_signals),
    .data_in             (data_in),
    .destination         (destination),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .control_signals_out (control_signals_out),
    .data_out            (data_out),
    .destination_out     (destination_out),
    .occupancy           (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [24:0] c, input logic [31:0] d, input logic [4:0] t);
    in_valid        = v;
    control_signals = c;
    data_in         = d;
    destination     = t;
  endtask

  // Offer one beat and hold it until the handshake completes (bounded).
  task automatic send(input logic [24:0] c, input logic [31:0] d, input logic [4:0] t);
    logic acc;
    acc = 1'b0;
    drive(1'b1, c, d, t);
    for (int i = 0; i < 20; i++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      chk("occupancy", 64'(occupancy), 64'(sb_q.size()));
      if (!out_valid)
        chk("bubble_payload", 64'({control_signals_out, data_out, destination_out}), 64'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 64'({control_signals_out, data_out, destination_out}), 64'h0);
          if ({control_signals_out, data_out, destination_out} == '0) begin
            nerr++;
            $display("FAIL unexpected_beat: got zero beat expected none");
          end
        end else begin
          chk("order", 64'({control_signals_out, data_out, destination_out}), 64'(sb_q.pop_front()));
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({control_signals, data_in, destination});
    end
  end

  initial begin
    logic acc;
    logic was_flush;
    logic [31:0] exp_bp [5];

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);

    // Reset for two cycles
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_data_out",  64'(data_out),  64'd0);

    // Stream 0x11..0x44, two-cycle latency, back-to-back output
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 25'(i), 32'(i * 'h11), 5'(i));
      tick();
      if (i == 1) chk("stream_lat", 64'(out_valid), 64'd0);
      else begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data",  64'(data_out),  64'((i - 1) * 'h11));
      end
    end
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stream_last", 64'(data_out), 64'h44);
    chk("stream_dest", 64'(destination_out), 64'd4);
    tick();
    chk("stream_idle", 64'(out_valid), 64'd0);

    // Backpressure: fill all four entries, E is held upstream
    out_ready = 1'b0;
    send(25'hA, 32'hA, 5'hA);
    send(25'hB, 32'hB, 5'hB);
    send(25'hC, 32'hC, 5'hC);
    send(25'hD, 32'hD, 5'hD);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ",      64'(occupancy), 64'd4);
    chk("bp_head",     64'(data_out), 64'hA);
    drive(1'b1, 25'hE, 32'hE, 5'hE);
    tick(); tick();
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_head",  64'(data_out), 64'hA);
    out_ready = 1'b1;
    exp_bp = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_valid", 64'(out_valid), 64'd1);
      chk("bp_drain_data",  64'(data_out),  64'(exp_bp[i]));
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_e_taken", 64'(in_valid), 64'd0);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full, with a beat offered in the flush cycle
    out_ready = 1'b0;
    send(25'h21, 32'h21, 5'h1);
    send(25'h22, 32'h22, 5'h2);
    send(25'h23, 32'h23, 5'h3);
    send(25'h24, 32'h24, 5'h4);
    chk("fl_full", 64'(occupancy), 64'd4);
    flush = 1'b1;
    drive(1'b1, 25'h1FF, 32'hDEAD, 5'h1F);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_occ",   64'(occupancy), 64'd0);
    chk("fl_payload", 64'({control_signals_out, data_out, destination_out}), 64'd0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("fl_no_dead", 64'(out_valid), 64'd0);

    // Bubble in the middle of a stream
    drive(1'b1, 25'h155, 32'h1234, 5'h3);
    tick();
    drive(1'b0, 25'h1ABCDEF, 32'hFFFF_FFFF, 5'h1F);
    tick();
    chk("bub_first_v", 64'(out_valid), 64'd1);
    chk("bub_first_c", 64'(control_signals_out), 64'h155);
    drive(1'b1, 25'h0AA, 32'h5678, 5'h7);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("bub_gap_v", 64'(out_valid), 64'd0);
    chk("bub_gap_c", 64'(control_signals_out), 64'd0);
    tick();
    chk("bub_second_v", 64'(out_valid), 64'd1);
    chk("bub_second_d", 64'(data_out), 64'h5678);
    tick();

    // Reset and flush together mid-stream
    out_ready = 1'b0;
    send(25'h61, 32'h61, 5'h1);
    send(25'h62, 32'h62, 5'h2);
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 25'h99, 32'h99, 5'h9);
    tick();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("rp_valid",    64'(out_valid), 64'd0);
    chk("rp_occ",      64'(occupancy), 64'd0);
    chk("rp_in_ready", 64'(in_ready),  64'd1);
    chk("rp_payload",  64'({control_signals_out, data_out, destination_out}), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 25'h55, 32'h55, 5'h5);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("rp_lat", 64'(out_valid), 64'd0);
    tick();
    chk("rp_new_v", 64'(out_valid), 64'd1);
    chk("rp_new_d", 64'(data_out), 64'h55);
    tick();

    // Random soak; upstream keeps a refused beat stable
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    for (int n = 0; n < 10000; n++) begin
      acc = in_valid && in_ready && !flush;
      was_flush = flush;
      tick();
      if (!in_valid || acc || was_flush)
        drive(1'($urandom_range(0, 1)), 25'($urandom), $urandom, 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) < 2);
    end

    // Drain everything that is still in flight
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
